cla_bist_controller: RTL

- Synthesizable built-in self-test sequencer for the 16-bit CLA adder/subtractor.
- It is the stimulus end of the CLA operand interface: it drives A, B and mode into the adder and samples S, Cout and Ovf back.
- It compares each sample against an internally computed golden result and reports pass/fail, a mismatch count and the first failing vector.
- It sits beside the CLA instance and is started by a single-cycle pulse from the system or bench.

---
 rtl/cla_pkg.sv | 50 +++++
 rtl/cla_bist_controller_lfsr32.sv | 26 ++
 rtl/cla_bist_controller.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cla_pkg.sv
// Shared types, constants, directed vectors and golden arithmetic
// for the CLA adder/subtractor self-test sequencer.
package cla_pkg;

   localparam int WIDTH = 16;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_CHECK,
      ST_DONE
   } state_e;

   typedef struct packed {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             mode;
   } vec_t;

   localparam vec_t DIR_VEC [8] = '{
      '{16'd25,    16'd10,    MODE_ADD},
      '{16'd32760, 16'd50,    MODE_ADD},
      '{16'd32000, 16'd16000, MODE_ADD},
      '{16'd32767, 16'd2,     MODE_ADD},
      '{16'd40,    16'd10,    MODE_SUB},
      '{16'd10,    16'd20,    MODE_SUB},
      '{16'd500,   16'd100,   MODE_SUB},
      '{16'd20,    16'd50,    MODE_SUB}
   };

   // Returns {cout, ovf, s}; subtract is A + ~B + 1 so cout=1 means no borrow
   function automatic logic [WIDTH+1:0] golden(
      input logic [WIDTH-1:0] a,
      input logic [WIDTH-1:0] b,
      input logic             mode
   );
      logic [WIDTH-1:0] bx;
      logic [WIDTH:0]   sum;
      logic             ovf;
      bx  = mode ? ~b : b;
      sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, mode};
      ovf = (a[WIDTH-1] == bx[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
      return {sum[WIDTH], ovf, sum[WIDTH-1:0]};
   endfunction

endpackage

// File: rtl/cla_bist_controller_lfsr32.sv
// 32-bit Fibonacci LFSR, x^32+x^22+x^2+x+1, shifting toward the MSB.
// Synchronous seed load has priority over the advance enable.
module lfsr32 #(
   parameter logic [31:0] SEED = 32'hACE11234
) (
   input  logic        clk,
   input  logic        load_i,
   input  logic        en_i,
   output logic [31:0] state_o
);

   logic [31:0] state_q;
   logic        fb;

   assign fb      = state_q[31] ^ state_q[21] ^ state_q[1] ^ state_q[0];
   assign state_o = state_q;

   always_ff @(posedge clk) begin
      if (load_i) begin
         state_q <= SEED;
      end else if (en_i) begin
         state_q <= {state_q[30:0], fb};
      end
   end

endmodule

// File: rtl/cla_bist_controller.sv
// BIST sequencer: drives directed then pseudo-random vectors into the CLA,
// checks each result against the golden model and reports pass/fail.
module cla_bist_controller #(
   parameter int          WIDTH         = 16,
   parameter int          N_RANDOM      = 64,
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [31:0] LFSR_SEED     = 32'hACE11234
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [WIDTH-1:0] cla_a,
   output logic [WIDTH-1:0] cla_b,
   output logic             cla_mode,
   input  logic [WIDTH-1:0] cla_s,
   input  logic             cla_cout,
   input  logic             cla_ovf,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [7:0]       fail_count,
   output logic [7:0]       first_fail_idx
);

   import cla_pkg::*;

   localparam logic [8:0] LAST_IDX    = 9'(N_RANDOM + 7);
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_e           state_q;
   logic [8:0]       idx_q;
   logic [3:0]       settle_q;
   logic [WIDTH+1:0] golden_q;
   logic [WIDTH-1:0] cla_a_q;
   logic [WIDTH-1:0] cla_b_q;
   logic             cla_mode_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [7:0]       fail_q;
   logic [7:0]       ffi_q;

   vec_t             vec_d;
   logic [7:0]       fail_d;
   logic             mismatch;
   logic             lfsr_en;
   logic [31:0]      lfsr_state;

   // Only random vectors consume LFSR state; it is never reseeded by start
   assign lfsr_en = (state_q == ST_LOAD) && (idx_q >= 9'd8);

   lfsr32 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk     (clk),
      .load_i  (rst),
      .en_i    (lfsr_en),
      .state_o (lfsr_state)
   );

   always_comb begin
      vec_d = DIR_VEC[idx_q[2:0]];
      if (idx_q >= 9'd8) begin
         vec_d = '{a: lfsr_state[31:16], b: lfsr_state[15:0], mode: idx_q[0]};
      end
   end

   assign mismatch = {cla_cout, cla_ovf, cla_s} != golden_q;

   always_comb begin
      fail_d = fail_q;
      if (mismatch && (fail_q != 8'hFF)) begin
         fail_d = fail_q + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         settle_q   <= '0;
         golden_q   <= '0;
         cla_a_q    <= '0;
         cla_b_q    <= '0;
         cla_mode_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         fail_q     <= '0;
         ffi_q      <= 8'hFF;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_LOAD;
                  idx_q   <= '0;
                  fail_q  <= '0;
                  ffi_q   <= 8'hFF;
                  pass_q  <= 1'b0;
                  busy_q  <= 1'b1;
               end
            end
            ST_LOAD: begin
               cla_a_q    <= vec_d.a;
               cla_b_q    <= vec_d.b;
               cla_mode_q <= vec_d.mode;
               golden_q   <= golden(vec_d.a, vec_d.b, vec_d.mode);
               settle_q   <= '0;
               state_q    <= ST_SETTLE;
            end
            ST_SETTLE: begin
               if (settle_q == SETTLE_LAST) begin
                  state_q <= ST_CHECK;
               end else begin
                  settle_q <= settle_q + 4'd1;
               end
            end
            ST_CHECK: begin
               fail_q <= fail_d;
               if (mismatch && (fail_q == 8'd0)) begin
                  ffi_q <= idx_q[7:0];
               end
               if (idx_q == LAST_IDX) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (fail_d == 8'd0);
               end else begin
                  idx_q   <= idx_q + 9'd1;
                  state_q <= ST_LOAD;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign cla_a          = cla_a_q;
   assign cla_b          = cla_b_q;
   assign cla_mode       = cla_mode_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign fail_count     = fail_q;
   assign first_fail_idx = ffi_q;

endmodule
